detector_sentido_barrera: RTL and testbench

Gate-side sensor decoder for the parking-lot counter. It watches two optical barrier sensors: outer `sensor_ext` (street side) and inner `sensor_int` (lot side). It synchronizes and debounces both, then tracks the crossing order with a direction FSM. For each complete crossing it emits one single-cycle pulse: `s` for a car entering, `r` for a car leaving. These pulses drive the counter's `s`/`r` inputs directly, on the same `clk`.

---
 rtl/detector_sentido_barrera.sv | 192 +++++++++++++++++++
 tb/tb_detector_sentido_barrera.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/detector_sentido_barrera.sv
// Two-beam gate decoder: synchronize and debounce ext/int, then track crossing order and pulse s (entry) or r (exit).
// Optional crossing-state timeout is built only when DETECTOR_TIMEOUT_EN is defined.
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | no beam blocked, no crossing in progress
// E1         | entry started: only ext blocked
// E2         | entry: both beams blocked
// E3         | entry: only int blocked, release completes entry
// S1         | exit started: only int blocked
// S2         | exit: both beams blocked
// S3         | exit: only ext blocked, release completes exit
// WAIT_CLEAR | illegal sequence or timeout, wait for both beams clear
module detector_sentido_barrera #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_ext,
    input  logic sensor_int,
    output logic s,
    output logic r,
    output logic ocupado,
    output logic error
);

    typedef enum logic [2:0] {
        IDLE,
        E1,
        E2,
        E3,
        S1,
        S2,
        S3,
        WAIT_CLEAR
    } state_t;

    localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // Bit 1 is ext, bit 0 is int, so the pair reads as {ext,int}.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [DW-1:0] db_cnt [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 2'b00;
            sync2     <= 2'b00;
            filt      <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= {sensor_ext, sensor_int};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    state_t state;
    state_t state_nxt;
    logic   s_nxt;
    logic   r_nxt;
    logic   err_nxt;
    logic   crossing;

    assign crossing = (state != IDLE) && (state != WAIT_CLEAR);

`ifdef DETECTOR_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = crossing && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst || !crossing || (state_nxt != state)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                case (filt)
                    2'b10:   state_nxt = E1;
                    2'b01:   state_nxt = S1;
                    2'b11: begin state_nxt = WAIT_CLEAR; err_nxt = 1'b1; end
                    default: state_nxt = IDLE;
                endcase
            end
            E1: begin
                case (filt)
                    2'b11:   state_nxt = E2;
                    2'b00:   state_nxt = IDLE;
                    2'b01: begin state_nxt = WAIT_CLEAR; err_nxt = 1'b1; end
                    default: state_nxt = E1;
                endcase
            end
            E2: begin
                case (filt)
                    2'b01:   state_nxt = E3;
                    2'b10:   state_nxt = E1;
                    2'b00: begin state_nxt = WAIT_CLEAR; err_nxt = 1'b1; end
                    default: state_nxt = E2;
                endcase
            end
            E3: begin
                case (filt)
                    2'b00: begin state_nxt = IDLE; s_nxt = 1'b1; end
                    2'b11:   state_nxt = E2;
                    2'b10: begin state_nxt = WAIT_CLEAR; err_nxt = 1'b1; end
                    default: state_nxt = E3;
                endcase
            end
            S1: begin
                case (filt)
                    2'b11:   state_nxt = S2;
                    2'b00:   state_nxt = IDLE;
                    2'b10: begin state_nxt = WAIT_CLEAR; err_nxt = 1'b1; end
                    default: state_nxt = S1;
                endcase
            end
            S2: begin
                case (filt)
                    2'b10:   state_nxt = S3;
                    2'b01:   state_nxt = S1;
                    2'b00: begin state_nxt = WAIT_CLEAR; err_nxt = 1'b1; end
                    default: state_nxt = S2;
                endcase
            end
            S3: begin
                case (filt)
                    2'b00: begin state_nxt = IDLE; r_nxt = 1'b1; end
                    2'b11:   state_nxt = S2;
                    2'b01: begin state_nxt = WAIT_CLEAR; err_nxt = 1'b1; end
                    default: state_nxt = S3;
                endcase
            end
            WAIT_CLEAR: begin
                if (filt == 2'b00) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`ifdef DETECTOR_TIMEOUT_EN
        // A stuck crossing abandons whatever the sensors are doing this cycle.
        if (tmo_hit) begin
            state_nxt = WAIT_CLEAR;
            s_nxt     = 1'b0;
            r_nxt     = 1'b0;
            err_nxt   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s       <= 1'b0;
            r       <= 1'b0;
            error   <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            state   <= state_nxt;
            s       <= s_nxt;
            r       <= r_nxt;
            error   <= err_nxt;
            ocupado <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_detector_sentido_barrera.sv
// Directed bench for detector_sentido_barrera with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.
// Timeout expectations follow DETECTOR_TIMEOUT_EN when the bench is built with it.
module tb_detector_sentido_barrera;

    localparam int DEB = 4;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst;
    logic sensor_ext;
    logic sensor_int;
    logic s;
    logic r;
    logic ocupado;
    logic error;

    int n_chk  = 0;
    int n_pass = 0;

    int s_cnt   = 0;
    int r_cnt   = 0;
    int err_cnt = 0;
    int occ_cnt = 0;

    int s0, r0, e0, o0;

    detector_sentido_barrera #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor_ext(sensor_ext),
        .sensor_int(sensor_int),
        .s         (s),
        .r         (r),
        .ocupado   (ocupado),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Outputs change only on rising edges, so one falling-edge sample per cycle counts pulses exactly.
    always @(negedge clk) begin
        if (s)       s_cnt   <= s_cnt + 1;
        if (r)       r_cnt   <= r_cnt + 1;
        if (error)   err_cnt <= err_cnt + 1;
        if (ocupado) occ_cnt <= occ_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic i, input int hold);
        sensor_ext = e;
        sensor_int = i;
        step(hold);
    endtask

    task automatic mark();
        s0 = s_cnt;
        r0 = r_cnt;
        e0 = err_cnt;
        o0 = occ_cnt;
    endtask

    initial begin
        rst        = 1'b1;
        sensor_ext = 1'b1;
        sensor_int = 1'b1;

        // Reset with both beams blocked
        step(2);
        chk("rst_s", int'(s), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_error", int'(error), 0);
        mark();
        rst = 1'b0;
        step(20);
        chk("rst_11_error_pulses", err_cnt - e0, 1);
        chk("rst_11_wait_clear", int'(ocupado), 1);
        drive(1'b0, 1'b0, 20);
        chk("rst_11_cleared", int'(ocupado), 0);
        chk("rst_11_no_s", s_cnt - s0, 0);
        chk("rst_11_no_r", r_cnt - r0, 0);

        // Clean entry with exact pulse latency
        mark();
        drive(1'b1, 1'b0, 20);
        chk("entry_ocupado_e1", int'(ocupado), 1);
        drive(1'b1, 1'b1, 20);
        drive(1'b0, 1'b1, 20);
        sensor_int = 1'b0;
        step(DEB + 2);
        chk("entry_s_early", int'(s), 0);
        step(1);
        chk("entry_s_at_7", int'(s), 1);
        chk("entry_ocupado_falls", int'(ocupado), 0);
        step(1);
        chk("entry_s_one_cycle", int'(s), 0);
        step(20);
        chk("entry_s_count", s_cnt - s0, 1);
        chk("entry_r_count", r_cnt - r0, 0);
        chk("entry_err_count", err_cnt - e0, 0);

        // Clean exit (mirror)
        mark();
        drive(1'b0, 1'b1, 20);
        drive(1'b1, 1'b1, 20);
        drive(1'b1, 1'b0, 20);
        sensor_ext = 1'b0;
        step(DEB + 2);
        chk("exit_r_early", int'(r), 0);
        step(1);
        chk("exit_r_at_7", int'(r), 1);
        step(20);
        chk("exit_r_count", r_cnt - r0, 1);
        chk("exit_s_count", s_cnt - s0, 0);
        chk("exit_err_count", err_cnt - e0, 0);

        // Glitch one cycle shorter than the filter window
        mark();
        drive(1'b1, 1'b0, DEB - 1);
        drive(1'b0, 1'b0, 20);
        chk("glitch_ocupado_cycles", occ_cnt - o0, 0);

        // Pulse of exactly the filter window passes: E1 for 4 cycles, then abort
        mark();
        drive(1'b1, 1'b0, DEB);
        drive(1'b0, 1'b0, 20);
        chk("pulse_db_ocupado_cycles", occ_cnt - o0, DEB);
        chk("pulse_db_no_error", err_cnt - e0, 0);

        // Back-out: ext, both, ext, none
        mark();
        drive(1'b1, 1'b0, 20);
        drive(1'b1, 1'b1, 20);
        drive(1'b1, 1'b0, 20);
        chk("backout_still_busy", int'(ocupado), 1);
        drive(1'b0, 1'b0, 20);
        chk("backout_ocupado", int'(ocupado), 0);
        chk("backout_no_s", s_cnt - s0, 0);
        chk("backout_no_error", err_cnt - e0, 0);

        // Illegal: ext only straight to int only
        mark();
        drive(1'b1, 1'b0, 20);
        drive(1'b0, 1'b1, 20);
        chk("illegal_error_count", err_cnt - e0, 1);
        chk("illegal_wait_clear", int'(ocupado), 1);
        drive(1'b0, 1'b0, 20);
        chk("illegal_cleared", int'(ocupado), 0);
        chk("illegal_no_s", s_cnt - s0, 0);
        chk("illegal_no_r", r_cnt - r0, 0);

        // Reset while in E3, int still blocked afterwards
        mark();
        drive(1'b1, 1'b0, 20);
        drive(1'b1, 1'b1, 20);
        drive(1'b0, 1'b1, 20);
        rst = 1'b1;
        step(2);
        chk("midrst_ocupado", int'(ocupado), 0);
        rst = 1'b0;
        step(20);
        drive(1'b0, 1'b0, 20);
        chk("midrst_no_s", s_cnt - s0, 0);
        chk("midrst_no_r", r_cnt - r0, 0);
        chk("midrst_no_error", err_cnt - e0, 0);
        chk("midrst_idle", int'(ocupado), 0);

        // Hold ext: E1 entered 7 edges after the raw rise
        mark();
        sensor_ext = 1'b1;
        step(DEB + 3 + TMO - 1);
        chk("tmo_error_early", int'(error), 0);
        step(1);
`ifdef DETECTOR_TIMEOUT_EN
        chk("tmo_error_at_50", int'(error), 1);
`else
        chk("tmo_no_error", int'(error), 0);
`endif
        step(100 - (DEB + 3 + TMO));
`ifdef DETECTOR_TIMEOUT_EN
        chk("tmo_error_count", err_cnt - e0, 1);
`else
        chk("tmo_error_count", err_cnt - e0, 0);
`endif
        chk("tmo_ocupado_held", int'(ocupado), 1);
        drive(1'b0, 1'b0, 20);
        chk("tmo_released", int'(ocupado), 0);
        chk("tmo_no_s", s_cnt - s0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
